// File: rtl/axi_pwm_cfg_pkg.sv
// axi_pwm_cfg_pkg: shared types and constants for the axi_pwm configuration sequencer.
// Defining PWM_CFG_READBACK_EN adds the read-back FSM states.
package axi_pwm_cfg_pkg;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [3:0] PWM_REG0 = 4'h0;
    localparam logic [3:0] PWM_REG1 = 4'h4;
    localparam logic [3:0] PWM_REG2 = 4'h8;
    localparam logic [3:0] PWM_REG3 = 4'hC;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WRESP,
`ifdef PWM_CFG_READBACK_EN
        S_RD,
        S_RDATA,
`endif
        S_POP
    } state_t;
    typedef struct packed {
        logic [1:0]  reg_idx;
        logic [31:0] data;
    } cmd_t;
    function automatic logic [3:0] reg_offset(input logic [1:0] idx);
        return {idx, 2'b00};
    endfunction
endpackage

// File: rtl/axi_pwm_cfg_sequencer_if.sv
// axi_pwm_cfg_sequencer_if: AXI4-Lite bundle between the sequencer (master) and axi_pwm (slave).
interface axi_pwm_cfg_sequencer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   AWADDR;
    logic [2:0]      AWPROT;
    logic            AWVALID, AWREADY;
    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WVALID, WREADY;
    logic [1:0]      BRESP;
    logic            BVALID, BREADY;
    logic [AW-1:0]   ARADDR;
    logic [2:0]      ARPROT;
    logic            ARVALID, ARREADY;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RVALID, RREADY;
    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/pwm_cfg_fifo.sv
// pwm_cfg_fifo: synchronous command FIFO; a push while full is accepted only alongside a pop.
module pwm_cfg_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [PW:0] cnt_q;
    logic wr, rd;
    assign wr = push & (~full | pop);
    assign rd = pop & ~empty;
    assign full = cnt_q == (PW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign dout = mem[rp_q];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
        end else begin
            wp_q <= wp_q + PW'(wr);
            rp_q <= rp_q + PW'(rd);
            cnt_q <= cnt_q + (PW+1)'(wr) - (PW+1)'(rd);
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wp_q] <= din;
    end
endmodule

// File: rtl/axi_pwm_cfg_sequencer.sv
// axi_pwm_cfg_sequencer: queues (register, data) commands and writes them to axi_pwm over AXI4-Lite.
// PWM_CFG_READBACK_EN adds a read-back compare after each write.
module axi_pwm_cfg_sequencer
    import axi_pwm_cfg_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_reg,
    input  logic [31:0] cmd_data,
    output logic        busy,
    output logic        err,
    input  logic        err_clr,
    axi_pwm_cfg_sequencer_if.master m_axi
);
    state_t state_q, state_d;
    cmd_t cmd_q, head;
    logic aw_done_q, w_done_q, aw_ok, w_ok, tmo, set_err, full, empty, init_q, err_q;
    logic [7:0] cnt_q;
    pwm_cfg_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(cmd_t))) u_fifo (
        .clk(ACLK),
        .rst_n(ARESETN),
        .push(cmd_valid & cmd_ready),
        .pop(state_q == S_POP),
        .din({cmd_reg, cmd_data}),
        .dout(head),
        .full(full),
        .empty(empty)
    );
    assign aw_ok = aw_done_q | (m_axi.AWVALID & m_axi.AWREADY);
    assign w_ok = w_done_q | (m_axi.WVALID & m_axi.WREADY);
    assign tmo = cnt_q == 8'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= S_IDLE;
            cmd_q <= '0;
            aw_done_q <= 1'b0;
            w_done_q <= 1'b0;
            cnt_q <= '0;
            err_q <= 1'b0;
            init_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && !empty) cmd_q <= head;
            aw_done_q <= state_q == S_WR && aw_ok;
            w_done_q <= state_q == S_WR && w_ok;
            cnt_q <= state_d != state_q ? '0 : cnt_q + 8'd1;
            err_q <= set_err | (err_q & ~err_clr);
            init_q <= 1'b1;
        end
    end
    // Handshake completion beats a timeout landing on the same cycle.
    always_comb begin
        state_d = state_q;
        set_err = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = empty ? S_IDLE : S_WR;
            S_WR: begin
                if (aw_ok && w_ok) state_d = S_WRESP;
                else if (tmo) begin
                    set_err = 1'b1;
                    state_d = S_POP;
                end
            end
            S_WRESP: begin
                if (m_axi.BVALID) begin
                    set_err = m_axi.BRESP != RESP_OKAY;
`ifdef PWM_CFG_READBACK_EN
                    state_d = S_RD;
`else
                    state_d = S_POP;
`endif
                end else if (tmo) begin
                    set_err = 1'b1;
                    state_d = S_POP;
                end
            end
`ifdef PWM_CFG_READBACK_EN
            S_RD: begin
                if (m_axi.ARREADY) state_d = S_RDATA;
                else if (tmo) begin
                    set_err = 1'b1;
                    state_d = S_POP;
                end
            end
            S_RDATA: begin
                if (m_axi.RVALID) begin
                    set_err = m_axi.RRESP != RESP_OKAY || m_axi.RDATA != C_M_AXI_DATA_WIDTH'(cmd_q.data);
                    state_d = S_POP;
                end else if (tmo) begin
                    set_err = 1'b1;
                    state_d = S_POP;
                end
            end
`endif
            S_POP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    assign cmd_ready = init_q & ~full;
    assign busy = ~empty | (state_q != S_IDLE);
    assign err = err_q;
    assign m_axi.AWADDR = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'(reg_offset(cmd_q.reg_idx));
    assign m_axi.AWPROT = 3'b000;
    assign m_axi.AWVALID = state_q == S_WR && !aw_done_q;
    assign m_axi.WDATA = C_M_AXI_DATA_WIDTH'(cmd_q.data);
    assign m_axi.WSTRB = '1;
    assign m_axi.WVALID = state_q == S_WR && !w_done_q;
    assign m_axi.BREADY = state_q == S_WRESP;
`ifdef PWM_CFG_READBACK_EN
    assign m_axi.ARADDR = m_axi.AWADDR;
    assign m_axi.ARPROT = 3'b000;
    assign m_axi.ARVALID = state_q == S_RD;
    assign m_axi.RREADY = state_q == S_RDATA;
`else
    logic unused_rd;
    assign unused_rd = ^{m_axi.ARREADY, m_axi.RDATA, m_axi.RRESP, m_axi.RVALID};
    assign m_axi.ARADDR = '0;
    assign m_axi.ARPROT = 3'b000;
    assign m_axi.ARVALID = 1'b0;
    assign m_axi.RREADY = 1'b0;
`endif
endmodule

// File: tb/tb_axi_pwm_cfg_sequencer.sv
// tb_axi_pwm_cfg_sequencer: directed vectors plus hand-written corner sequences for the PWM config sequencer.
module tb_axi_pwm_cfg_sequencer;
    localparam logic [31:0] BASE = 32'h43C0_0000;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0, err_clr = 1'b0;
    logic cmd_ready, busy, err;
    logic [1:0] cmd_reg = '0;
    logic [31:0] cmd_data = '0;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    axi_pwm_cfg_sequencer_if #(.AW(32), .DW(32)) m_axi ();
    axi_pwm_cfg_sequencer #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .C_BASE_ADDR(BASE),
        .FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .ACLK(clk),
        .ARESETN(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_reg(cmd_reg),
        .cmd_data(cmd_data),
        .busy(busy),
        .err(err),
        .err_clr(err_clr),
        .m_axi(m_axi)
    );
    typedef struct {
        logic [1:0]  r;
        logic [31:0] d;
        int          awd;
        int          wd;
        logic [1:0]  bresp;
        logic [31:0] ea;
        logic        e;
    } vec_t;
    vec_t tbl[8];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask
    task automatic push(input logic [1:0] r, input logic [31:0] d, output logic acc);
        cmd_valid = 1'b1;
        cmd_reg = r;
        cmd_data = d;
        acc = cmd_ready;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask
    // Acts as the slave for one write; returns at the negedge after the final handshake.
    task automatic serve(input vec_t v, input string nm);
        int t = 0, awn = 0, wn = 0;
        bit awdn = 0, wdn = 0, awh, wh;
        while (!m_axi.AWVALID && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_awvalid"}, 32'(m_axi.AWVALID), 1);
        chk({nm, "_awaddr"}, m_axi.AWADDR, v.ea);
        chk({nm, "_wdata"}, m_axi.WDATA, v.d);
        t = 0;
        while (!(awdn && wdn) && t < 50) begin
            m_axi.AWREADY = !awdn && t >= v.awd;
            m_axi.WREADY = !wdn && t >= v.wd;
            awn += int'(m_axi.AWVALID);
            wn += int'(m_axi.WVALID);
            awh = m_axi.AWREADY & m_axi.AWVALID;
            wh = m_axi.WREADY & m_axi.WVALID;
            @(negedge clk);
            awdn |= awh;
            wdn |= wh;
            t++;
        end
        m_axi.AWREADY = 1'b0;
        m_axi.WREADY = 1'b0;
        chk({nm, "_awcycles"}, 32'(awn), 32'(v.awd + 1));
        chk({nm, "_wcycles"}, 32'(wn), 32'(v.wd + 1));
        chk({nm, "_bready"}, 32'(m_axi.BREADY), 1);
        m_axi.BVALID = 1'b1;
        m_axi.BRESP = v.bresp;
        @(negedge clk);
        m_axi.BVALID = 1'b0;
        m_axi.BRESP = 2'b00;
`ifdef PWM_CFG_READBACK_EN
        chk({nm, "_arvalid"}, 32'(m_axi.ARVALID), 1);
        chk({nm, "_araddr"}, m_axi.ARADDR, v.ea);
        m_axi.ARREADY = 1'b1;
        @(negedge clk);
        m_axi.ARREADY = 1'b0;
        m_axi.RVALID = 1'b1;
        m_axi.RDATA = v.d;
        @(negedge clk);
        m_axi.RVALID = 1'b0;
`else
        chk({nm, "_ar_tied"}, {30'd0, m_axi.ARVALID, m_axi.RREADY}, 0);
`endif
        chk({nm, "_bready_drop"}, 32'(m_axi.BREADY), 0);
        chk({nm, "_err"}, 32'(err), 32'(v.e));
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        logic acc;
        vec_t v;
        int n;
        m_axi.AWREADY = 0; m_axi.WREADY = 0; m_axi.BVALID = 0; m_axi.BRESP = 0;
        m_axi.ARREADY = 0; m_axi.RVALID = 0; m_axi.RDATA = 0; m_axi.RRESP = 0;
        tbl[0] = '{2'd0, 32'h0101FFFF, 0, 0, 2'b00, 32'h43C00000, 1'b0};
        tbl[1] = '{2'd1, 32'habcd0001, 0, 0, 2'b00, 32'h43C00004, 1'b0};
        tbl[2] = '{2'd2, 32'hdead0011, 0, 0, 2'b00, 32'h43C00008, 1'b0};
        tbl[3] = '{2'd3, 32'hbeef0011, 0, 0, 2'b00, 32'h43C0000C, 1'b0};
        tbl[4] = '{2'd2, 32'h12345678, 3, 0, 2'b00, 32'h43C00008, 1'b0};
        tbl[5] = '{2'd1, 32'hcafe0001, 0, 0, 2'b10, 32'h43C00004, 1'b1};
        tbl[6] = '{2'd3, 32'h0badf00d, 0, 2, 2'b00, 32'h43C0000C, 1'b1};
        tbl[7] = '{2'd0, 32'h00000000, 1, 1, 2'b00, 32'h43C00000, 1'b1};
        repeat (3) @(negedge clk);
        chk("rst_valids", {29'd0, m_axi.AWVALID, m_axi.WVALID, m_axi.BREADY}, 0);
        chk("rst_err_busy", {30'd0, err, busy}, 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        rst_n = 1'b1;
        #1 chk("rel_cmd_ready_0", 32'(cmd_ready), 0);
        @(negedge clk);
        chk("rel_cmd_ready_1", 32'(cmd_ready), 1);
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 4; i++) begin
                push(tbl[g*4+i].r, tbl[g*4+i].d, acc);
                chk($sformatf("push%0d", g*4+i), 32'(acc), 1);
            end
            for (int i = 0; i < 4; i++) serve(tbl[g*4+i], $sformatf("v%0d", g*4+i));
            chk($sformatf("busy_g%0d_pop", g), 32'(busy), 1);
            @(negedge clk);
            chk($sformatf("busy_g%0d_done", g), 32'(busy), 0);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", 32'(err), 0);
        for (int i = 0; i < 5; i++) begin
            push(2'(i), 32'hF000_0000 + 32'(i), acc);
            chk($sformatf("full_push%0d", i), 32'(acc), 32'(i < 4));
        end
        for (int i = 0; i < 4; i++) begin
            v = '{2'(i), 32'hF000_0000 + 32'(i), 0, 0, 2'b00, BASE + 32'(4 * i), 1'b0};
            serve(v, $sformatf("full%0d", i));
        end
        @(negedge clk);
        chk("full_5th_dropped", 32'(busy), 0);
        push(2'd1, 32'h5555_AAAA, acc);
        n = 0;
        while (!m_axi.AWVALID && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (m_axi.AWVALID && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_cycles", 32'(n), 255);
        chk("tmo_err", 32'(err), 1);
        chk("tmo_valids", {30'd0, m_axi.AWVALID, m_axi.WVALID}, 0);
        @(negedge clk);
        chk("tmo_idle", 32'(busy), 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        push(2'd0, 32'h1111_0000, acc);
        push(2'd1, 32'h2222_0001, acc);
        n = 0;
        while (!m_axi.AWVALID && n < 20) begin
            @(negedge clk);
            n++;
        end
        #2 rst_n = 1'b0;
        #1 chk("arst_valids", {30'd0, m_axi.AWVALID, m_axi.WVALID}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(cmd_ready), 1);
        push(2'd3, 32'h7777_0003, acc);
        serve('{2'd3, 32'h7777_0003, 0, 0, 2'b00, 32'h43C0000C, 1'b0}, "post_rst");
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
